// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 DCT transpose buffer.
// DCT_TRANSPOSE_SKIP_ZERO_EN: upstream forces coefficients 6/7 to zero, so only columns 0..5 are kept.
// Used by dct_tp_bank and dct_transpose_buf.
package dct_pkg;

    localparam int BW_DEF = 11;
    localparam int N      = 8;

`ifdef DCT_TRANSPOSE_SKIP_ZERO_EN
    // Columns 6 and 7 are known zero upstream; neither stored nor emitted.
    localparam int NCOL = 6;
`else
    localparam int NCOL = 8;
`endif

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_t;

endpackage

// File: rtl/dct_tp_bank.sv
// One 8 x NC bank: row-wide write port, combinational column-wide read port.
// Latency: write lands at the clock edge; read is combinational (zero cycles).
// Backpressure: none here; the parent only writes or reads when its handshake allows.
module dct_tp_bank import dct_pkg::*; #(
    parameter int BW = BW_DEF,
    parameter int NC = NCOL
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [2:0]        wr_row,
    input  logic [NC*BW-1:0]  wr_dat,
    input  logic [2:0]        rd_col,
    output logic [N*BW-1:0]   rd_dat
);

    // Storage is deliberately left unreset; validity is tracked by the bank state in the parent.
    logic [BW-1:0] mem [N][NC];

    // Write all NC elements of one row; element 0 sits in the MSB slot of wr_dat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < NC; c++) begin
                mem[wr_row][c] <= wr_dat[(NC-1-c)*BW +: BW];
            end
        end
    end

    // Gather one column; row 0 goes to the MSB slot, matching the row packing.
    always_comb begin
        rd_dat = '0;
        for (int r = 0; r < N; r++) begin
            rd_dat[(N-1-r)*BW +: BW] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in, columns out; DCT_TRANSPOSE_SKIP_ZERO_EN emits only columns 0..5.
// Latency: column 0 is valid the cycle after the 8th row of a block is accepted.
// Backpressure: in_ready drops while the write bank is still FULL; outputs hold while out_ready is low.
module dct_transpose_buf import dct_pkg::*; #(
    parameter int BW = BW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*BW-1:0]   in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8*BW-1:0]   out_col,
    output logic [2:0]        out_col_idx,
    output logic              out_last
);

    localparam logic [2:0] LAST_COL = 3'(NCOL - 1);

    bank_st_t          bank_st     [2];
    bank_st_t          bank_st_nxt [2];
    logic              wbank;
    logic              rbank;
    logic [2:0]        wrow;
    logic [2:0]        rcol;
    logic              wr_acc;
    logic              rd_acc;
    logic              col_last;
    logic [1:0]        wr_en;
    logic [N*BW-1:0]   rd_dat0;
    logic [N*BW-1:0]   rd_dat1;
    logic [NCOL*BW-1:0] wr_dat;

    assign in_ready  = (bank_st[wbank] != FULL);
    assign out_valid = (bank_st[rbank] == FULL);
    assign wr_acc    = in_valid && in_ready;
    assign rd_acc    = out_valid && out_ready;
    assign col_last  = (rcol == LAST_COL);

    assign wr_en[0]  = wr_acc && !wbank;
    assign wr_en[1]  = wr_acc &&  wbank;
    // Only the leading NCOL elements of a row are stored.
    assign wr_dat    = in_row[N*BW-1 -: NCOL*BW];

    // Bank state next-state: a bank can't be written and drained in the same cycle
    // (writes need non-FULL, reads need FULL), so the two updates never collide.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_nxt[b] = bank_st[b];
            if (wr_acc && (wbank == 1'(b))) begin
                bank_st_nxt[b] = (wrow == 3'd7) ? FULL : FILLING;
            end
            if (rd_acc && col_last && (rbank == 1'(b))) begin
                bank_st_nxt[b] = EMPTY;
            end
        end
    end

    // Bank states and write/read pointers; reset discards any partial or pending block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            wrow       <= 3'd0;
            rcol       <= 3'd0;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
            if (wr_acc) begin
                wrow <= wrow + 3'd1;
                if (wrow == 3'd7) begin
                    wbank <= ~wbank;
                end
            end
            if (rd_acc) begin
                if (col_last) begin
                    rcol  <= 3'd0;
                    rbank <= ~rbank;
                end else begin
                    rcol  <= rcol + 3'd1;
                end
            end
        end
    end

    dct_tp_bank #(.BW(BW), .NC(NCOL)) u_bank0 (
        .clk    (clk),
        .wr_en  (wr_en[0]),
        .wr_row (wrow),
        .wr_dat (wr_dat),
        .rd_col (rcol),
        .rd_dat (rd_dat0)
    );

    dct_tp_bank #(.BW(BW), .NC(NCOL)) u_bank1 (
        .clk    (clk),
        .wr_en  (wr_en[1]),
        .wr_row (wrow),
        .wr_dat (wr_dat),
        .rd_col (rcol),
        .rd_dat (rd_dat1)
    );

    // Output mux from the read bank; everything is forced to zero when no column is valid.
    always_comb begin
        out_col     = '0;
        out_col_idx = 3'd0;
        out_last    = 1'b0;
        if (out_valid) begin
            out_col     = rbank ? rd_dat1 : rd_dat0;
            out_col_idx = rcol;
            out_last    = col_last;
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Bench for dct_transpose_buf: directed table plus random traffic against a queue-based model.
// Latency: expects column 0 one cycle after the 8th row of a block.
// Backpressure: drives out_ready low/high patterns and checks in_ready against block occupancy.
module tb_dct_transpose_buf;

    localparam int BW = 11;
    localparam int W  = 8*BW;
`ifdef DCT_TRANSPOSE_SKIP_ZERO_EN
    localparam int NC = 6;
`else
    localparam int NC = 8;
`endif
    localparam int NV = 8 + NC + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_row;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_col;
    logic [2:0]    out_col_idx;
    logic          out_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dct_transpose_buf #(.BW(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_col     (out_col),
        .out_col_idx (out_col_idx),
        .out_last    (out_last)
    );

    // Reference model: rows of completed, not yet drained blocks (8 per block),
    // rows of the block being assembled, and the next column to be read.
    logic [W-1:0] full_rows[$];
    logic [W-1:0] part_rows[$];
    int           col_i = 0;

    typedef struct {
        logic         iv;
        logic [W-1:0] row;
        logic         ordy;
        logic         e_rdy;
        logic         e_vld;
        logic [2:0]   e_idx;
        logic         e_last;
        logic [W-1:0] e_col;
    } vec_t;

    vec_t vt [NV];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [BW-1:0] elem(input logic [W-1:0] row, input int c);
        return row[(7-c)*BW +: BW];
    endfunction

    function automatic logic [W-1:0] exp_col(input int c);
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) v[(7-r)*BW +: BW] = elem(full_rows[r], c);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[(7-c)*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    // One clock: check outputs against the model, apply inputs, advance model after the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] row, input logic ordy);
        logic exp_rdy, exp_vld, wr, rd;
        in_valid  = iv;
        in_row    = row;
        out_ready = ordy;
        exp_rdy   = (full_rows.size() < 16);
        exp_vld   = (full_rows.size() >= 8);
        check("in_ready", W'(in_ready), W'(exp_rdy));
        check("out_valid", W'(out_valid), W'(exp_vld));
        if (exp_vld) begin
            check("out_col", out_col, exp_col(col_i));
            check("out_col_idx", W'(out_col_idx), W'(col_i));
            check("out_last", W'(out_last), W'(col_i == NC-1));
        end else begin
            check("idle_col", out_col, '0);
            check("idle_idx", W'(out_col_idx), '0);
            check("idle_last", W'(out_last), '0);
        end
        wr = iv && exp_rdy;
        rd = exp_vld && ordy;
        @(posedge clk);
        #1;
        if (rd) begin
            col_i++;
            if (col_i == NC) begin
                col_i = 0;
                repeat (8) void'(full_rows.pop_front());
            end
        end
        if (wr) begin
            part_rows.push_back(row);
            if (part_rows.size() == 8) begin
                while (part_rows.size() > 0) full_rows.push_back(part_rows.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_row    = rand_row();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        full_rows.delete();
        part_rows.delete();
        col_i = 0;
    endtask

    // Drain pending columns within a fixed budget, then the DUT must be idle.
    task automatic drain();
        for (int k = 0; k < 64 && full_rows.size() > 0; k++) cycle(1'b0, '0, 1'b1);
        check("drain_out_valid", W'(out_valid), '0);
    endtask

    initial begin
        logic [W-1:0]      v;
        logic [2*BW-1:0]   want_pair;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_out_col", out_col, '0);
        check("rst_out_idx", W'(out_col_idx), '0);
        check("rst_out_last", W'(out_last), '0);

        // Directed single block: element[r][c] = 16*r + c.
        for (int r = 0; r < 8; r++) begin
            v = '0;
            for (int c = 0; c < 8; c++) v[(7-c)*BW +: BW] = BW'(16*r + c);
            vt[r] = '{iv: 1'b1, row: v, ordy: 1'b1, e_rdy: 1'b1, e_vld: 1'b0,
                      e_idx: 3'd0, e_last: 1'b0, e_col: '0};
        end
        for (int c = 0; c < NC; c++) begin
            v = '0;
            for (int r = 0; r < 8; r++) v[(7-r)*BW +: BW] = BW'(16*r + c);
            vt[8+c] = '{iv: 1'b0, row: '0, ordy: 1'b1, e_rdy: 1'b1, e_vld: 1'b1,
                        e_idx: 3'(c), e_last: (c == NC-1), e_col: v};
        end
        vt[NV-1] = '{iv: 1'b0, row: '0, ordy: 1'b1, e_rdy: 1'b1, e_vld: 1'b0,
                     e_idx: 3'd0, e_last: 1'b0, e_col: '0};

        for (int i = 0; i < NV; i++) begin
            check("tbl_in_ready", W'(in_ready), W'(vt[i].e_rdy));
            check("tbl_out_valid", W'(out_valid), W'(vt[i].e_vld));
            check("tbl_out_col", out_col, vt[i].e_col);
            check("tbl_out_idx", W'(out_col_idx), W'(vt[i].e_idx));
            check("tbl_out_last", W'(out_last), W'(vt[i].e_last));
            cycle(vt[i].iv, vt[i].row, vt[i].ordy);
        end

        // Back-pressure: hold column 0, fill second bank, then in_ready must drop.
        do_reset();
        for (int r = 0; r < 8; r++) cycle(1'b1, rand_row(), 1'b0);
        for (int k = 0; k < 10; k++) begin
            check("bp_hold_idx", W'(out_col_idx), '0);
            cycle(1'b0, '0, 1'b0);
        end
        for (int r = 0; r < 8; r++) cycle(1'b1, rand_row(), 1'b0);
        check("bp_in_ready_low", W'(in_ready), '0);
        for (int k = 0; k < 3; k++) cycle(1'b1, rand_row(), 1'b0);
        drain();

        // Streaming: four blocks back to back, in_ready must never drop.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            check("stream_in_ready", W'(in_ready), W'(1'b1));
            cycle(1'b1, rand_row(), 1'b1);
        end
        drain();

        // Extreme signed values pass through bit-exact.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            v = '0;
            for (int c = 0; c < 8; c++) v[(7-c)*BW +: BW] = ((r + c) % 2 == 1) ? 11'h3FF : 11'h400;
            cycle(1'b1, v, 1'b0);
        end
        want_pair = {11'h400, 11'h3FF};
        check("neg_col0_top", W'(out_col[W-1 -: 2*BW]), W'(want_pair));
        drain();

        // Reset mid-operation with one full block and a partial one pending.
        do_reset();
        for (int r = 0; r < 13; r++) cycle(1'b1, rand_row(), 1'b0);
        do_reset();
        check("mid_rst_in_ready", W'(in_ready), W'(1'b1));
        check("mid_rst_out_valid", W'(out_valid), '0);
        check("mid_rst_out_col", out_col, '0);
        for (int r = 0; r < 8; r++) cycle(1'b1, rand_row(), 1'b1);
        drain();

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, rand_row(), $urandom_range(0, 2) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
